// File: rtl/serial_rx_mc.sv
// rtl/serial_rx_mc.sv - multi-lane serial word receiver timed off a shared count timebase
module serial_rx_mc #(
    parameter int P_NCH       = 4,
    parameter int P_DW        = 32,
    parameter int P_LSB_FIRST = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [P_NCH-1:0]       a,
    input  logic                   start,
    input  logic [7:0]             nbits,
    input  logic [31:0]            n0,
    input  logic [31:0]            n1,
    input  logic [31:0]            cnt,
    output logic [P_NCH*P_DW-1:0]  data,
    output logic                   valid,
    output logic                   busy,
    output logic                   start_ign
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT0, S_SHIFT} state_t;

    localparam logic [7:0] NB_MAX = 8'((P_DW > 255) ? 255 : P_DW);

    state_t                state_q;
    logic [31:0]           t_q;
    logic [31:0]           n1_q;
    logic [7:0]            nb_q;
    logic [7:0]            bitcnt_q;
    logic [P_DW-1:0]       sh_q [P_NCH];
    logic [P_DW-1:0]       sh_d [P_NCH];
    logic [P_NCH*P_DW-1:0] data_q;
    logic                  valid_q;
    logic                  start_ign_q;

    logic [31:0]           n0_clamp;
    logic [31:0]           n1_clamp;
    logic [7:0]            nb_clamp;
    logic [P_DW-1:0]       bit_mask;
    logic                  hit;
    logic                  last_bit;

    always_comb begin
        n0_clamp = (n0 == 32'd0) ? 32'd1 : n0;
        n1_clamp = (n1 == 32'd0) ? 32'd1 : n1;
        if (nbits == 8'd0) begin
            nb_clamp = 8'd1;
        end else if (nbits > NB_MAX) begin
            nb_clamp = NB_MAX;
        end else begin
            nb_clamp = nbits;
        end
    end

    // Equality only: cnt wrap-around needs no special handling.
    assign hit      = (cnt == t_q);
    assign last_bit = (bitcnt_q == nb_q - 8'd1);
    assign bit_mask = {{(P_DW-1){1'b0}}, 1'b1} << bitcnt_q;

    // Next shift-register contents if this cycle is a sample instant.
    always_comb begin
        for (int k = 0; k < P_NCH; k++) begin
            if (P_LSB_FIRST != 0) begin
                sh_d[k] = sh_q[k] | (a[k] ? bit_mask : '0);
            end else begin
                sh_d[k] = {sh_q[k][P_DW-2:0], a[k]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            t_q         <= '0;
            n1_q        <= '0;
            nb_q        <= '0;
            bitcnt_q    <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            start_ign_q <= 1'b0;
            for (int k = 0; k < P_NCH; k++) sh_q[k] <= '0;
        end else begin
            valid_q     <= 1'b0;
            start_ign_q <= start && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n1_q     <= n1_clamp;
                        nb_q     <= nb_clamp;
                        t_q      <= cnt + n0_clamp;
                        bitcnt_q <= '0;
                        for (int k = 0; k < P_NCH; k++) sh_q[k] <= '0;
                        state_q  <= S_WAIT0;
                    end
                end
                S_WAIT0: begin
                    if (hit) begin
                        t_q     <= t_q + n1_q;
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (hit) begin
                        for (int k = 0; k < P_NCH; k++) sh_q[k] <= sh_d[k];
                        bitcnt_q <= bitcnt_q + 8'd1;
                        t_q      <= t_q + n1_q;
                        if (last_bit) begin
                            for (int k = 0; k < P_NCH; k++) data_q[k*P_DW +: P_DW] <= sh_d[k];
                            valid_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign busy      = (state_q != S_IDLE);
    assign start_ign = start_ign_q;

endmodule
